sia_txq: RTL

//  Transmit queue between sia_wb (writer) and the SIA transmitter shifter (reader).
//  - Synchronous first-word-fall-through (FWFT) FIFO: 16-bit words, power-of-two depth.
//  - Write side matches sia_wb txq_we_o/txq_dat_o/txq_not_full_i/txq_empty_i.
//  - Read side gives the transmitter the head word plus a pop strobe.

---
 rtl/sia_txq.sv | 88 ++++++++
 1 files changed

// File: rtl/sia_txq.sv
// sia_txq: transmit queue between sia_wb (writer) and the SIA transmitter shifter (reader).
// First-word-fall-through FIFO with DATA_WIDTH-bit words and 2**ADDR_BITS entries.
// The head word is on dat_o with no read latency, and it reads 0 while the queue is empty.
// ovf_o is sticky: once a push is dropped it stays set until flush_i or reset.
// Optional build macro SIA_TXQ_LEVEL_EN adds the level_o port (current word count).
module sia_txq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  flush_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  not_full_o,
  output logic                  empty_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  not_empty_o,
  output logic                  ovf_o
`ifdef SIA_TXQ_LEVEL_EN
  ,
  output logic [ADDR_BITS:0]    level_o
`endif
);

  localparam int                 DEPTH    = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wp;
  logic [ADDR_BITS-1:0]  rp;
  logic [ADDR_BITS:0]    count;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  push_drop;

  // Flags, head word and the accept/drop decisions, all derived from count.
  // A full queue still takes a push when a pop frees a slot in the same cycle.
  always_comb begin
    empty_o     = (count == '0);
    not_empty_o = ~empty_o;
    not_full_o  = (count != FULL_CNT);
    dat_o       = not_empty_o ? mem[rp] : '0;
    pop_acc     = pop_i & not_empty_o;
    push_acc    = we_i & (not_full_o | pop_acc);
    push_drop   = we_i & ~not_full_o & ~pop_acc;
  end

`ifdef SIA_TXQ_LEVEL_EN
  // The level output is simply the word count.
  always_comb begin
    level_o = count;
  end
`endif

  // Storage is written on every accepted push. It has no reset because flags gate every read.
  always_ff @(posedge clk_i) begin
    if (push_acc && !flush_i) begin
      mem[wp] <= dat_i;
    end
  end

  // Pointers, count and the sticky overflow flag. Flush overrides push and pop in the same cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf_o <= 1'b0;
    end else if (flush_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (push_acc) wp <= wp + 1'b1;
      if (pop_acc)  rp <= rp + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_drop) ovf_o <= 1'b1;
    end
  end

endmodule
